instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Upstream timing/fetch stage for the control-logic decoder.
- Fetches an instruction word, latches it into the instruction register and drives one-hot phase strobes T1..T4, one per cycle.
- Holds the architectural Zflag/Cflag registers that the decoder consumes and commands updates to.
- Supports stall (phase freeze) and halt opcode; presents Opcode, T1..T4, Zflag, Cflag directly to the decoder.

Parameters:
- INSTR_W, 16, instruction word width; opcode is the upper OPC_W bits.
- OPC_W, 5, opcode width (matches decoder select width).
- HALT_OPC, 5'h1F, opcode that stops sequencing after its T4.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- Reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- Run  in  1  leave IDLE and start fetching.
- FetchReq  out  1  request next instruction word from program memory.
- InstrIn  in  INSTR_W  instruction word from program memory.
- InstrValid  in  1  InstrIn valid this cycle; completes fetch handshake.
- Stall  in  1  freeze current phase (memory/port wait).
- ZflagIn  in  1  zero result from ALU.
- CflagIn  in  1  carry result from ALU.
- ZflagSave  in  1  decoder command: capture ZflagIn.
- CflagSave  in  1  decoder command: capture CflagIn.
- T1, T2, T3, T4  out  1 each  one-hot phase strobes.
- Opcode  out  OPC_W  IR[INSTR_W-1 -: OPC_W].
- Operand  out  INSTR_W-OPC_W  IR low bits.
- Zflag  out  1  registered zero flag.
- Cflag  out  1  registered carry flag.
- Halted  out  1  sequencer in HALT.

Behaviour:
- States: IDLE, FETCH, PH1, PH2, PH3, PH4, HALT. All outputs registered.
- Reset (Reset=0, asynchronous): state=IDLE, IR=0, Zflag=0, Cflag=0, FetchReq=0, T1..T4=0, Halted=0. Reset mid-phase aborts the instruction; no flag update completes.
- IDLE: all strobes 0. Run=1 moves to FETCH next cycle.
- FETCH: FetchReq=1. On InstrValid=1, latch IR<=InstrIn and go to PH1; FetchReq drops the same edge. No timeout; waits indefinitely. Stall is ignored in FETCH.
- PH1..PH4: exactly one of T1..T4 = 1, matching the state. Advances PH1->PH2->PH3->PH4 each cycle.
- After PH4:
  - Opcode==HALT_OPC: go to HALT.
  - Otherwise: go to FETCH. Back-to-back instructions take 4 phases + ≥1 fetch cycle.
- Stall=1 in a PHn state: state holds, all T outputs forced 0 (combinational gate on the registered strobe). Release re-asserts the same Tn for one full cycle. Stall during PH4 delays the HALT/FETCH decision.
- Flags:
  - Zflag<=ZflagIn on an edge where ZflagSave=1, state is PH1..PH4 and Stall=0; likewise Cflag.
  - Save inputs are ignored in IDLE/FETCH/HALT.
  - Simultaneous ZflagSave and CflagSave both update.
- IR is stable from PH1 through PH4. Opcode is only changed by a fetch.
- HALT: Halted=1, strobes 0, FetchReq=0. Exit only via reset; Run is ignored.

Optional Feature:
- Macro SEQ_INSTR_COUNT_EN.
- Defined: adds output InstrCount [15:0], reset 0, incremented on each PH4 exit with Stall=0 (including the halt instruction). Wraps 16'hFFFF->0.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package seq_pkg: state enum (seq_state_t), OPC_W, INSTR_W defaults, HALT_OPC constant.
- One sub-module, seq_phase_ring: 4-bit one-hot ring with enable (advance), clear and stall gate, instantiated by instr_sequencer.

Test Plan:
- Reset/run: release Reset, Run=1, InstrValid=1 with InstrIn=16'h0A05 -> FetchReq=1 for one cycle, Opcode=5'h01, Operand=11'h205, T1,T2,T3,T4 each high one cycle consecutively, then FetchReq=1 again.
- Stall: assert Stall for 3 cycles during PH2 -> T2 low during stall, state frozen, T2 high one cycle after release, total instruction length 7 cycles.
- Flags: ZflagIn=1, CflagIn=1, ZflagSave=1 in PH2, CflagSave=1 in PH1 -> Cflag=1 after PH1 edge, Zflag=1 after PH2 edge. Same with Stall=1 -> flags unchanged.
- Halt: fetch 16'hF800 -> completes T1..T4, Halted=1, FetchReq stays 0 for 20 cycles despite Run=1.
- Async reset mid-PH3: drive Reset=0 between edges -> T3, IR, flags cleared immediately, state IDLE.
- SEQ_INSTR_COUNT_EN: 5 instructions retired -> InstrCount=5. Preload near 16'hFFFF via forced run -> wraps to 0.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and default widths for the instruction sequencer.
package seq_pkg;

  localparam int DEF_INSTR_W = 16;
  localparam int DEF_OPC_W = 5;
  localparam logic [DEF_OPC_W-1:0] DEF_HALT_OPC = 5'h1F;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_PH1   = 3'd2,
    S_PH2   = 3'd3,
    S_PH3   = 3'd4,
    S_PH4   = 3'd5,
    S_HALT  = 3'd6
  } seq_state_t;

endpackage

// File: rtl/seq_phase_ring.sv
// One-hot phase strobe register: loads T1, shifts once per unstalled phase,
// and is gated to zero combinationally while stalled.
module seq_phase_ring (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clr,
  input  logic       i_start,
  input  logic       i_adv,
  input  logic       i_stall,
  output logic [3:0] o_t
);

  logic [3:0] r_ring;

  // Shifting out of bit 3 leaves the ring empty for the following fetch/halt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ring <= 4'b0000;
    end else if (i_clr) begin
      r_ring <= 4'b0000;
    end else if (i_start) begin
      r_ring <= 4'b0001;
    end else if (i_adv && !i_stall) begin
      r_ring <= {r_ring[2:0], 1'b0};
    end
  end

  assign o_t = i_stall ? 4'b0000 : r_ring;

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/phase sequencer feeding the control decoder: IR, T1..T4, Zflag/Cflag.
// Optional retired-instruction counter enabled with SEQ_INSTR_COUNT_EN.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int                INSTR_W  = DEF_INSTR_W,
  parameter int                OPC_W    = DEF_OPC_W,
  parameter logic [OPC_W-1:0]  HALT_OPC = DEF_HALT_OPC
) (
  input  logic                     clk,
  input  logic                     Reset,
  input  logic                     Run,
  output logic                     FetchReq,
  input  logic [INSTR_W-1:0]       InstrIn,
  input  logic                     InstrValid,
  input  logic                     Stall,
  input  logic                     ZflagIn,
  input  logic                     CflagIn,
  input  logic                     ZflagSave,
  input  logic                     CflagSave,
  output logic                     T1,
  output logic                     T2,
  output logic                     T3,
  output logic                     T4,
  output logic [OPC_W-1:0]         Opcode,
  output logic [INSTR_W-OPC_W-1:0] Operand,
  output logic                     Zflag,
  output logic                     Cflag,
  output logic                     Halted,
`ifdef SEQ_INSTR_COUNT_EN
  output logic [15:0]              InstrCount,
`endif
  output seq_state_t               o_dbg_state
);

  seq_state_t         r_state;
  logic [INSTR_W-1:0] r_ir;
  logic               r_fetch_req;
  logic               r_halted;
  logic               r_zflag;
  logic               r_cflag;

  logic       w_in_phase;
  logic       w_fetch_done;
  logic       w_ph_adv;
  logic       w_ring_clr;
  logic [3:0] w_t;

  assign w_in_phase   = (r_state == S_PH1) || (r_state == S_PH2) ||
                        (r_state == S_PH3) || (r_state == S_PH4);
  // Fetch handshake: a word transfers on any edge where FetchReq (the FETCH
  // state) and InstrValid are both high; there is no backpressure on the memory.
  assign w_fetch_done = (r_state == S_FETCH) && InstrValid;
  assign w_ph_adv     = w_in_phase && !Stall;
  assign w_ring_clr   = (r_state == S_IDLE) || (r_state == S_HALT);

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_state     <= S_IDLE;
      r_ir        <= '0;
      r_fetch_req <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Run) begin
            r_state     <= S_FETCH;
            r_fetch_req <= 1'b1;
          end
        end
        S_FETCH: begin
          if (InstrValid) begin
            r_ir        <= InstrIn;
            r_state     <= S_PH1;
            r_fetch_req <= 1'b0;
          end
        end
        S_PH1: if (!Stall) r_state <= S_PH2;
        S_PH2: if (!Stall) r_state <= S_PH3;
        S_PH3: if (!Stall) r_state <= S_PH4;
        S_PH4: begin
          if (!Stall) begin
            if (r_ir[INSTR_W-1 -: OPC_W] == HALT_OPC) begin
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end else begin
              r_state     <= S_FETCH;
              r_fetch_req <= 1'b1;
            end
          end
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_zflag <= 1'b0;
      r_cflag <= 1'b0;
    end else if (w_ph_adv) begin
      if (ZflagSave) r_zflag <= ZflagIn;
      if (CflagSave) r_cflag <= CflagIn;
    end
  end

`ifdef SEQ_INSTR_COUNT_EN
  logic [15:0] r_instr_count;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_instr_count <= 16'h0000;
    end else if ((r_state == S_PH4) && !Stall) begin
      r_instr_count <= r_instr_count + 16'h0001;
    end
  end

  assign InstrCount = r_instr_count;
`endif

  seq_phase_ring u_ring (
    .clk     (clk),
    .rst_n   (Reset),
    .i_clr   (w_ring_clr),
    .i_start (w_fetch_done),
    .i_adv   (w_in_phase),
    .i_stall (Stall),
    .o_t     (w_t)
  );

  assign T1          = w_t[0];
  assign T2          = w_t[1];
  assign T3          = w_t[2];
  assign T4          = w_t[3];
  assign FetchReq    = r_fetch_req;
  assign Halted      = r_halted;
  assign Zflag       = r_zflag;
  assign Cflag       = r_cflag;
  assign Opcode      = r_ir[INSTR_W-1 -: OPC_W];
  assign Operand     = r_ir[INSTR_W-OPC_W-1:0];
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed vector bench for instr_sequencer: fetch, phases, stall, flags,
// halt and asynchronous reset.
module tb_instr_sequencer;
  import seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        fetch_req;
  logic [15:0] instr_in = 16'h0000;
  logic        instr_valid = 1'b0;
  logic        stall = 1'b0;
  logic        zflag_in = 1'b0;
  logic        cflag_in = 1'b0;
  logic        zflag_save = 1'b0;
  logic        cflag_save = 1'b0;
  logic        t1, t2, t3, t4;
  logic [4:0]  opcode;
  logic [10:0] operand;
  logic        zflag, cflag, halted;
  seq_state_t  dbg_state;
`ifdef SEQ_INSTR_COUNT_EN
  logic [15:0] instr_count;
`endif

  instr_sequencer dut (
    .clk         (clk),
    .Reset       (rst_n),
    .Run         (run),
    .FetchReq    (fetch_req),
    .InstrIn     (instr_in),
    .InstrValid  (instr_valid),
    .Stall       (stall),
    .ZflagIn     (zflag_in),
    .CflagIn     (cflag_in),
    .ZflagSave   (zflag_save),
    .CflagSave   (cflag_save),
    .T1          (t1),
    .T2          (t2),
    .T3          (t3),
    .T4          (t4),
    .Opcode      (opcode),
    .Operand     (operand),
    .Zflag       (zflag),
    .Cflag       (cflag),
    .Halted      (halted),
`ifdef SEQ_INSTR_COUNT_EN
    .InstrCount  (instr_count),
`endif
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // {FetchReq, T4..T1, Opcode, Zflag, Cflag, Halted}
  localparam int W = 13;

  typedef struct {
    logic        run;
    logic        iv;
    logic [15:0] instr;
    logic        stall;
    logic        zi;
    logic        ci;
    logic        zs;
    logic        cs;
    logic        fetch;
    logic [3:0]  t;
    logic [4:0]  opc;
    logic        z;
    logic        c;
    logic        h;
  } vec_t;

  logic [W-1:0] exp_q[$];
  vec_t         tbl[23];
  int           n_vec = 0;
  int           n_err = 0;

  function automatic vec_t mk(input logic run_i, input logic iv_i, input logic [15:0] instr_i,
                              input logic stall_i, input logic zi_i, input logic ci_i,
                              input logic zs_i, input logic cs_i, input logic fetch_i,
                              input logic [3:0] t_i, input logic [4:0] opc_i,
                              input logic z_i, input logic c_i, input logic h_i);
    vec_t v;
    v.run = run_i; v.iv = iv_i; v.instr = instr_i; v.stall = stall_i;
    v.zi = zi_i; v.ci = ci_i; v.zs = zs_i; v.cs = cs_i;
    v.fetch = fetch_i; v.t = t_i; v.opc = opc_i; v.z = z_i; v.c = c_i; v.h = h_i;
    return v;
  endfunction

  function automatic logic [W-1:0] pack_out();
    return {fetch_req, t4, t3, t2, t1, opcode, zflag, cflag, halted};
  endfunction

  // scoreboard
  task automatic check_outputs(input string name);
    logic [W-1:0] exp_w;
    logic [W-1:0] act_w;
    exp_w = exp_q.pop_front();
    act_w = pack_out();
    n_vec++;
    if (act_w !== exp_w) begin
      n_err++;
      $display("FAIL %s: outputs got %h expected %h", name, act_w, exp_w);
    end
  endtask

  task automatic check_val(input string name, input logic [15:0] act, input logic [15:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  // drivers
  task automatic drive_inputs(input logic r, input logic iv, input logic [15:0] ins,
                              input logic st, input logic zi, input logic ci,
                              input logic zs, input logic cs);
    run = r; instr_valid = iv; instr_in = ins; stall = st;
    zflag_in = zi; cflag_in = ci; zflag_save = zs; cflag_save = cs;
  endtask

  task automatic apply_row(input vec_t v, input int idx);
    @(negedge clk);
    drive_inputs(v.run, v.iv, v.instr, v.stall, v.zi, v.ci, v.zs, v.cs);
    exp_q.push_back({v.fetch, v.t, v.opc, v.z, v.c, v.h});
    #1;
    check_outputs($sformatf("row%0d", idx));
  endtask

  initial begin
    //           run iv instr     st zi ci zs cs  fr  T       opc    z  c  h
    tbl[0]  = mk(1, 0, 16'h0000, 0, 0, 0, 0, 0,  0, 4'b0000, 5'h00, 0, 0, 0);
    tbl[1]  = mk(1, 1, 16'h0A05, 0, 0, 0, 0, 0,  1, 4'b0000, 5'h00, 0, 0, 0);
    tbl[2]  = mk(0, 0, 16'h0000, 0, 0, 1, 0, 1,  0, 4'b0001, 5'h01, 0, 0, 0);
    tbl[3]  = mk(0, 0, 16'h0000, 0, 1, 0, 1, 0,  0, 4'b0010, 5'h01, 0, 1, 0);
    tbl[4]  = mk(0, 0, 16'h0000, 0, 0, 0, 0, 0,  0, 4'b0100, 5'h01, 1, 1, 0);
    tbl[5]  = mk(0, 0, 16'h0000, 0, 0, 0, 0, 0,  0, 4'b1000, 5'h01, 1, 1, 0);
    tbl[6]  = mk(0, 1, 16'h1234, 0, 0, 0, 0, 0,  1, 4'b0000, 5'h01, 1, 1, 0);
    tbl[7]  = mk(0, 0, 16'h0000, 0, 0, 0, 0, 0,  0, 4'b0001, 5'h02, 1, 1, 0);
    tbl[8]  = mk(0, 0, 16'h0000, 1, 0, 0, 1, 1,  0, 4'b0000, 5'h02, 1, 1, 0);
    tbl[9]  = mk(0, 0, 16'h0000, 1, 0, 0, 1, 1,  0, 4'b0000, 5'h02, 1, 1, 0);
    tbl[10] = mk(0, 0, 16'h0000, 1, 0, 0, 1, 1,  0, 4'b0000, 5'h02, 1, 1, 0);
    tbl[11] = mk(0, 0, 16'h0000, 0, 0, 0, 0, 0,  0, 4'b0010, 5'h02, 1, 1, 0);
    tbl[12] = mk(0, 0, 16'h0000, 0, 0, 0, 0, 0,  0, 4'b0100, 5'h02, 1, 1, 0);
    tbl[13] = mk(0, 0, 16'h0000, 0, 0, 0, 0, 0,  0, 4'b1000, 5'h02, 1, 1, 0);
    tbl[14] = mk(0, 0, 16'h0000, 1, 0, 0, 1, 0,  1, 4'b0000, 5'h02, 1, 1, 0);
    tbl[15] = mk(0, 1, 16'hF800, 1, 0, 0, 0, 0,  1, 4'b0000, 5'h02, 1, 1, 0);
    tbl[16] = mk(0, 0, 16'h0000, 0, 0, 0, 1, 0,  0, 4'b0001, 5'h1F, 1, 1, 0);
    tbl[17] = mk(0, 0, 16'h0000, 0, 0, 0, 0, 0,  0, 4'b0010, 5'h1F, 0, 1, 0);
    tbl[18] = mk(0, 0, 16'h0000, 0, 0, 0, 0, 0,  0, 4'b0100, 5'h1F, 0, 1, 0);
    tbl[19] = mk(0, 0, 16'h0000, 1, 0, 0, 0, 0,  0, 4'b0000, 5'h1F, 0, 1, 0);
    tbl[20] = mk(0, 0, 16'h0000, 0, 0, 0, 0, 0,  0, 4'b1000, 5'h1F, 0, 1, 0);
    tbl[21] = mk(1, 1, 16'h0A05, 0, 1, 0, 1, 1,  0, 4'b0000, 5'h1F, 0, 1, 1);
    tbl[22] = mk(1, 1, 16'h0A05, 0, 1, 0, 1, 1,  0, 4'b0000, 5'h1F, 0, 1, 1);

    // reset state while Reset is held low
    repeat (2) @(negedge clk);
    #1;
    exp_q.push_back('0);
    check_outputs("reset_state");
    check_val("reset_dbg_state", {13'd0, dbg_state}, {13'd0, S_IDLE});
    check_val("reset_operand", {5'd0, operand}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 23; i++) begin
      apply_row(tbl[i], i);
      if (i == 2) check_val("operand_0a05", {5'd0, operand}, 16'h0205);
    end

`ifdef SEQ_INSTR_COUNT_EN
    check_val("instr_count_at_halt", instr_count, 16'd3);
`endif

    // halted: Run keeps toggling in, nothing leaves HALT
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive_inputs(1'b1, 1'b1, 16'h0A05, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      exp_q.push_back({1'b0, 4'b0000, 5'h1F, 1'b0, 1'b1, 1'b1});
      check_outputs($sformatf("halt_hold%0d", i));
    end

    // asynchronous reset in the middle of PH3
    @(negedge clk);
    rst_n = 1'b0;
    drive_inputs(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive_inputs(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive_inputs(1'b0, 1'b1, 16'h0A05, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive_inputs(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    drive_inputs(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    exp_q.push_back({1'b0, 4'b0100, 5'h01, 1'b1, 1'b1, 1'b0});
    check_outputs("pre_reset_ph3");
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.push_back('0);
    check_outputs("async_reset_ph3");
    check_val("async_reset_dbg_state", {13'd0, dbg_state}, {13'd0, S_IDLE});
`ifdef SEQ_INSTR_COUNT_EN
    check_val("async_reset_count", instr_count, 16'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    exp_q.push_back('0);
    check_outputs("idle_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
